zoom_param_ctrl: RTL and testbench
==================================

# zoom_param_ctrl

Single-clock configuration controller for the crop-and-scale video path. It accepts a zoom window request, clamps and validates it, and computes the scaler's `inputXRes`, `inputYRes`, `xScale` and `yScale` with one shared sequential divider instead of a combinational divide. It commits the new parameter set atomically on the next frame-start pulse, so the cropper and scaler never see a half-updated window mid-frame. It sits between the host/key-control logic and the cropper/scaler inputs.

## Interface
- `H_DISP`, 1920, active pixels per line
- `V_DISP`, 1080, active lines per frame
- `X_RES_WIDTH`, 11, width of horizontal coordinates/resolutions
- `Y_RES_WIDTH`, 11, width of vertical coordinates/resolutions
- `SCALE_INT_BITS`, 4, integer bits of the scale factor
- `SCALE_FRAC_BITS`, 14, fraction bits of the scale factor (fixed)

Ports:
- `clk`  in  1  pixel-domain clock; the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `vs_i`  in  1  one-cycle frame-start pulse (same clock)
- `req_valid`  in  1  request strobe
- `req_ready`  out  1  request can be accepted
- `req_start_x` / `req_end_x`  in  X_RES_WIDTH  requested window columns
- `req_start_y` / `req_end_y`  in  Y_RES_WIDTH  requested window rows
- `req_out_x_res` / `req_out_y_res`  in  X/Y_RES_WIDTH  output resolution minus 1
- `start_x`, `end_x`, `start_y`, `end_y`  out  X/Y_RES_WIDTH  active window
- `input_x_res`, `input_y_res`  out  X/Y_RES_WIDTH  active end − start − 1
- `output_x_res`, `output_y_res`  out  X/Y_RES_WIDTH  active output resolution minus 1
- `x_scale`, `y_scale`  out  SCALE_INT_BITS+SCALE_FRAC_BITS  active Q4.14 scale factors
- `busy`  out  1  high in CHECK, DIV_X or DIV_Y
- `pending`  out  1  a computed set is waiting for `vs_i`
- `req_err`  out  1  one-cycle pulse when a request is rejected

## Operation
- **States:** IDLE, CHECK, DIV_X, DIV_Y, PEND.
- **Ready:** `req_ready` = state is IDLE or PEND.
- **Accept:** a request is accepted when `req_valid && req_ready`. The request fields are latched and the state goes to CHECK.
- **CHECK (1 cycle): reject conditions.** The request is rejected if any of the following holds:
  - `end_x > H_DISP`
  - `end_y > V_DISP`
  - `end_x < start_x + 2`
  - `end_y < start_y + 2`
- **CHECK, reject:** pulse `req_err` and return to IDLE. Any previously pending set was discarded at accept time.
- **CHECK, accept:** compute `in_x = end_x − start_x − 1` and `in_y = end_y − start_y − 1`, then go to DIV_X.
- **Division:** restoring, 25 iterations, 1 bit per cycle.
  - DIV_X: numerator `(in_x+1) << 14` (25 bits), denominator `out_x_res+1` (12 bits).
  - DIV_Y: same form with the y values.
- **Saturation:** if quotient bits [24:18] are nonzero, the scale saturates to `18'h3FFFF`. Otherwise the scale is quotient[17:0].
- **Completion:** after DIV_Y finishes, go to PEND.
- **PEND:**
  - On `vs_i`, copy the shadow set to the active outputs and go to IDLE.
  - A new accepted request in PEND discards the shadow set (last wins) and goes to CHECK.
  - If `vs_i` and an accept occur in the same cycle, commit the old shadow set first, then start the new request.
- **`vs_i` outside PEND** is ignored.
- **Width rules:** all subtractions are done after validation, so no wrap-around is possible. The denominator is never zero because `out_res+1` is at least 1 at 12 bits.

## Timing
- **Reset values:**
  - `start_x`=0, `start_y`=0, `end_x`=H_DISP, `end_y`=V_DISP
  - `input_x_res`=`output_x_res`=H_DISP−1, `input_y_res`=`output_y_res`=V_DISP−1
  - `x_scale`=`y_scale`=18'h04000
  - `busy`=0, `pending`=0, `req_err`=0, `req_ready`=1, state IDLE
- **Latency:** accept edge T → CHECK at T+1 → PEND reached 51 cycles after accept (1 + 25 + 25).
- **Commit:** active outputs change on the edge that samples `vs_i`=1 in PEND and are visible the following cycle. All outputs update on the same edge.
- **`req_err`:** pulses the cycle after CHECK.
- **Reset mid-operation:** asynchronous return to the reset values. The shadow set and divider state are cleared.

## Structure
- **Shared package `zoom_pkg`:** `SCALE_BITS` (= 18), `SCALE_ONE` (= 18'h04000), `SCALE_SAT` (= 18'h3FFFF), and the state enumeration.
- **Sub-module `seq_divider`:** 25-bit ÷ 12-bit restoring divider with `start`/`done`, instantiated once and reused for x then y.

## Test plan
- **Reset:** assert `rst` asynchronously → all outputs take their reset values; `x_scale`=18'h04000; `req_ready`=1.
- **2× zoom:** request window 480..1440 × 270..810 with out 1919×1079 → `pending` high 51 cycles after accept. After the next `vs_i`: `input_x_res`=959, `input_y_res`=539, `x_scale`=`y_scale`=18'h02000.
- **Rejection:** request `end_x` = `start_x`+1 → `req_err` pulses once; state IDLE; active outputs unchanged.
- **Saturation:** request window 0..1920 with out res 63 → `x_scale`=18'h3FFFF.
- **`vs_i` ignored while busy:** assert `vs_i` during DIV_X → no commit. A second request accepted in PEND replaces the first; the next `vs_i` commits only the second.
- **Same-cycle events:** `vs_i` and an accepted request in the same PEND cycle → the old set commits and the new request enters CHECK. Asserting `rst` during DIV_Y returns all outputs to their reset values.

Source files
------------

// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared constants and state encoding for the zoom parameter controller
package zoom_pkg;

  localparam int          SCALE_BITS = 18;
  localparam logic [17:0] SCALE_ONE  = 18'h04000;
  localparam logic [17:0] SCALE_SAT  = 18'h3FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIV_X,
    ST_DIV_Y,
    ST_PEND
  } zoom_state_e;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per cycle
// done/quot are combinational and describe the result of the iteration completing this edge.
module seq_divider #(
  parameter int NUM_W = 25,
  parameter int DEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quot
);

  localparam int CNT_W = $clog2(NUM_W);

  logic [NUM_W-1:0] num_sr;
  logic [NUM_W-1:0] quo_r;
  logic [DEN_W-1:0] den_r;
  logic [DEN_W-1:0] rem_r;
  logic [CNT_W-1:0] cnt;
  logic             active;

  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   trial_sub;
  logic             fits;

  assign trial     = {rem_r, num_sr[NUM_W-1]};
  assign fits      = trial >= {1'b0, den_r};
  assign trial_sub = fits ? (trial - {1'b0, den_r}) : trial;
  assign quot      = {quo_r[NUM_W-2:0], fits};
  assign done      = active && (cnt == CNT_W'(NUM_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_sr <= '0;
      quo_r  <= '0;
      den_r  <= '0;
      rem_r  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      num_sr <= num;
      quo_r  <= '0;
      den_r  <= den;
      rem_r  <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      // remainder stays below den, so the top trial bit is always shed here
      num_sr <= {num_sr[NUM_W-2:0], 1'b0};
      quo_r  <= quot;
      rem_r  <= trial_sub[DEN_W-1:0];
      cnt    <= cnt + CNT_W'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/zoom_param_ctrl.sv
// rtl/zoom_param_ctrl.sv - validates a zoom window, computes scale factors, commits on frame start
module zoom_param_ctrl
  import zoom_pkg::*;
#(
  parameter int H_DISP          = 1920,
  parameter int V_DISP          = 1080,
  parameter int X_RES_WIDTH     = 11,
  parameter int Y_RES_WIDTH     = 11,
  parameter int SCALE_INT_BITS  = 4,
  parameter int SCALE_FRAC_BITS = 14
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   vs_i,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [X_RES_WIDTH-1:0]                 req_start_x,
  input  logic [X_RES_WIDTH-1:0]                 req_end_x,
  input  logic [Y_RES_WIDTH-1:0]                 req_start_y,
  input  logic [Y_RES_WIDTH-1:0]                 req_end_y,
  input  logic [X_RES_WIDTH-1:0]                 req_out_x_res,
  input  logic [Y_RES_WIDTH-1:0]                 req_out_y_res,
  output logic [X_RES_WIDTH-1:0]                 start_x,
  output logic [X_RES_WIDTH-1:0]                 end_x,
  output logic [Y_RES_WIDTH-1:0]                 start_y,
  output logic [Y_RES_WIDTH-1:0]                 end_y,
  output logic [X_RES_WIDTH-1:0]                 input_x_res,
  output logic [Y_RES_WIDTH-1:0]                 input_y_res,
  output logic [X_RES_WIDTH-1:0]                 output_x_res,
  output logic [Y_RES_WIDTH-1:0]                 output_y_res,
  output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] x_scale,
  output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] y_scale,
  output logic                                   busy,
  output logic                                   pending,
  output logic                                   req_err
);

  localparam int SCALE_W = SCALE_INT_BITS + SCALE_FRAC_BITS;
  localparam int NUM_W   = X_RES_WIDTH + SCALE_FRAC_BITS;
  localparam int DEN_W   = X_RES_WIDTH + 1;

  zoom_state_e state, state_nxt;

  logic [X_RES_WIDTH-1:0] r_sx, r_ex, r_ox;
  logic [Y_RES_WIDTH-1:0] r_sy, r_ey, r_oy;
  logic [SCALE_W-1:0]     sh_xs, sh_ys;

  logic             accept, bad, reject, commit, div_start, div_done;
  logic [NUM_W-1:0] div_num, div_quot;
  logic [DEN_W-1:0] div_den;
  logic [SCALE_W-1:0] quot_sat;
  logic [X_RES_WIDTH-1:0] x_span;
  logic [Y_RES_WIDTH-1:0] y_span;

  assign req_ready = (state == ST_IDLE) || (state == ST_PEND);
  assign busy      = (state == ST_CHECK) || (state == ST_DIV_X) || (state == ST_DIV_Y);
  assign pending   = (state == ST_PEND);
  assign accept    = req_valid && req_ready;

  // one extra bit so start+2 cannot wrap
  assign bad = ({1'b0, r_ex} > (X_RES_WIDTH+1)'(H_DISP))
            || ({1'b0, r_ey} > (Y_RES_WIDTH+1)'(V_DISP))
            || ({1'b0, r_ex} < {1'b0, r_sx} + (X_RES_WIDTH+1)'(2))
            || ({1'b0, r_ey} < {1'b0, r_sy} + (Y_RES_WIDTH+1)'(2));

  assign x_span  = r_ex - r_sx;
  assign y_span  = r_ey - r_sy;
  assign div_num = (state == ST_CHECK) ? NUM_W'({x_span, {SCALE_FRAC_BITS{1'b0}}})
                                       : NUM_W'({y_span, {SCALE_FRAC_BITS{1'b0}}});
  assign div_den = (state == ST_CHECK) ? (DEN_W'(r_ox) + DEN_W'(1))
                                       : (DEN_W'(r_oy) + DEN_W'(1));
  assign quot_sat = (|div_quot[NUM_W-1:SCALE_W]) ? SCALE_SAT : div_quot[SCALE_W-1:0];

  seq_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    reject    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (bad) begin
          reject    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          div_start = 1'b1;
          state_nxt = ST_DIV_X;
        end
      end
      ST_DIV_X: if (div_done) begin
        div_start = 1'b1;
        state_nxt = ST_DIV_Y;
      end
      ST_DIV_Y: if (div_done) state_nxt = ST_PEND;
      ST_PEND: begin
        // a simultaneous accept still lets the old shadow set commit first
        if (vs_i) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
        if (accept) state_nxt = ST_CHECK;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sx <= '0; r_ex <= X_RES_WIDTH'(H_DISP); r_ox <= X_RES_WIDTH'(H_DISP - 1);
      r_sy <= '0; r_ey <= Y_RES_WIDTH'(V_DISP); r_oy <= Y_RES_WIDTH'(V_DISP - 1);
      sh_xs <= SCALE_ONE;
      sh_ys <= SCALE_ONE;
      start_x <= '0; end_x <= X_RES_WIDTH'(H_DISP);
      start_y <= '0; end_y <= Y_RES_WIDTH'(V_DISP);
      input_x_res  <= X_RES_WIDTH'(H_DISP - 1);
      input_y_res  <= Y_RES_WIDTH'(V_DISP - 1);
      output_x_res <= X_RES_WIDTH'(H_DISP - 1);
      output_y_res <= Y_RES_WIDTH'(V_DISP - 1);
      x_scale <= SCALE_ONE;
      y_scale <= SCALE_ONE;
      req_err <= 1'b0;
    end else begin
      req_err <= reject;
      if (commit) begin
        start_x      <= r_sx;
        end_x        <= r_ex;
        start_y      <= r_sy;
        end_y        <= r_ey;
        input_x_res  <= x_span - X_RES_WIDTH'(1);
        input_y_res  <= y_span - Y_RES_WIDTH'(1);
        output_x_res <= r_ox;
        output_y_res <= r_oy;
        x_scale      <= sh_xs;
        y_scale      <= sh_ys;
      end
      if (accept) begin
        r_sx <= req_start_x; r_ex <= req_end_x; r_ox <= req_out_x_res;
        r_sy <= req_start_y; r_ey <= req_end_y; r_oy <= req_out_y_res;
      end
      if (state == ST_DIV_X && div_done) sh_xs <= quot_sat;
      if (state == ST_DIV_Y && div_done) sh_ys <= quot_sat;
    end
  end

endmodule

// File: tb/tb_zoom_param_ctrl.sv
// tb/tb_zoom_param_ctrl.sv - directed self-checking bench for zoom_param_ctrl
module tb_zoom_param_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vs_i = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_start_x = '0, req_end_x = '0, req_start_y = '0, req_end_y = '0;
  logic [10:0] req_out_x_res = '0, req_out_y_res = '0;
  logic [10:0] start_x, end_x, start_y, end_y;
  logic [10:0] input_x_res, input_y_res, output_x_res, output_y_res;
  logic [17:0] x_scale, y_scale;
  logic        busy, pending, req_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zoom_param_ctrl dut (
    .clk(clk), .rst(rst), .vs_i(vs_i),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_start_x(req_start_x), .req_end_x(req_end_x),
    .req_start_y(req_start_y), .req_end_y(req_end_y),
    .req_out_x_res(req_out_x_res), .req_out_y_res(req_out_y_res),
    .start_x(start_x), .end_x(end_x), .start_y(start_y), .end_y(end_y),
    .input_x_res(input_x_res), .input_y_res(input_y_res),
    .output_x_res(output_x_res), .output_y_res(output_y_res),
    .x_scale(x_scale), .y_scale(y_scale),
    .busy(busy), .pending(pending), .req_err(req_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [10:0] sx, ex, sy, ey, ox, oy);
    req_start_x = sx; req_end_x = ex; req_start_y = sy; req_end_y = ey;
    req_out_x_res = ox; req_out_y_res = oy;
  endtask

  task automatic send(input logic [10:0] sx, ex, sy, ey, ox, oy);
    @(negedge clk);
    set_req(sx, ex, sy, ey, ox, oy);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic pulse_vs;
    @(negedge clk);
    vs_i = 1'b1;
    @(posedge clk); #1;
    vs_i = 1'b0;
  endtask

  task automatic wait_pending(input string tag);
    int n = 0;
    while (pending !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(pending), 32'd1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_start_x"}, 32'(start_x), 32'd0);
    chk({pfx, "_end_x"},   32'(end_x),   32'd1920);
    chk({pfx, "_end_y"},   32'(end_y),   32'd1080);
    chk({pfx, "_in_x"},    32'(input_x_res), 32'd1919);
    chk({pfx, "_in_y"},    32'(input_y_res), 32'd1079);
    chk({pfx, "_out_x"},   32'(output_x_res), 32'd1919);
    chk({pfx, "_out_y"},   32'(output_y_res), 32'd1079);
    chk({pfx, "_x_scale"}, 32'(x_scale), 32'h04000);
    chk({pfx, "_y_scale"}, 32'(y_scale), 32'h04000);
    chk({pfx, "_busy"},    32'(busy),    32'd0);
    chk({pfx, "_pending"}, 32'(pending), 32'd0);
    chk({pfx, "_req_err"}, 32'(req_err), 32'd0);
    chk({pfx, "_ready"},   32'(req_ready), 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 chk_reset_vals("rst");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 2x zoom, exact 51-cycle latency
    send(480, 1440, 270, 810, 1919, 1079);
    chk("zoom_busy", 32'(busy), 32'd1);
    chk("zoom_ready_busy", 32'(req_ready), 32'd0);
    repeat (50) @(posedge clk);
    #1 chk("zoom_pend_50", 32'(pending), 32'd0);
    @(posedge clk); #1;
    chk("zoom_pend_51", 32'(pending), 32'd1);
    chk("zoom_ready_pend", 32'(req_ready), 32'd1);
    chk("zoom_no_early_commit", 32'(x_scale), 32'h04000);
    pulse_vs;
    chk("zoom_in_x", 32'(input_x_res), 32'd959);
    chk("zoom_in_y", 32'(input_y_res), 32'd539);
    chk("zoom_x_scale", 32'(x_scale), 32'h02000);
    chk("zoom_y_scale", 32'(y_scale), 32'h02000);
    chk("zoom_start_x", 32'(start_x), 32'd480);
    chk("zoom_end_y", 32'(end_y), 32'd810);
    chk("zoom_idle", 32'(pending), 32'd0);

    // smallest legal window, denominator 1
    send(10, 12, 20, 22, 0, 0);
    wait_pending("min_pend");
    pulse_vs;
    chk("min_in_x", 32'(input_x_res), 32'd1);
    chk("min_in_y", 32'(input_y_res), 32'd1);
    chk("min_x_scale", 32'(x_scale), 32'h08000);
    chk("min_y_scale", 32'(y_scale), 32'h08000);
    chk("min_start_y", 32'(start_y), 32'd20);

    // rejections: too narrow, end_x beyond display, end_y beyond display
    send(100, 101, 0, 1080, 10, 10);
    @(posedge clk); #1;
    chk("rej_narrow_err", 32'(req_err), 32'd1);
    chk("rej_narrow_ready", 32'(req_ready), 32'd1);
    chk("rej_narrow_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("rej_narrow_pulse", 32'(req_err), 32'd0);
    chk("rej_keep_scale", 32'(x_scale), 32'h08000);
    chk("rej_keep_sx", 32'(start_x), 32'd10);
    send(0, 1921, 0, 1080, 10, 10);
    @(posedge clk); #1;
    chk("rej_ex_err", 32'(req_err), 32'd1);
    send(0, 1920, 0, 1081, 10, 10);
    @(posedge clk); #1;
    chk("rej_ey_err", 32'(req_err), 32'd1);
    chk("rej_keep_in_x", 32'(input_x_res), 32'd1);

    // saturation
    send(0, 1920, 0, 1080, 63, 1079);
    wait_pending("sat_pend");
    pulse_vs;
    chk("sat_x_scale", 32'(x_scale), 32'h3FFFF);
    chk("sat_y_scale", 32'(y_scale), 32'h04000);
    chk("sat_in_x", 32'(input_x_res), 32'd1919);
    chk("sat_out_x", 32'(output_x_res), 32'd63);

    // vs_i while dividing is ignored; a request in PEND replaces the shadow set
    send(0, 960, 0, 540, 479, 269);
    repeat (4) @(posedge clk);
    #1 chk("vsb_busy", 32'(busy), 32'd1);
    pulse_vs;
    chk("vsb_no_commit", 32'(x_scale), 32'h3FFFF);
    chk("vsb_still_busy", 32'(busy), 32'd1);
    wait_pending("vsb_pend1");
    chk("vsb_pend_no_commit", 32'(x_scale), 32'h3FFFF);
    send(0, 1920, 0, 1080, 1919, 269);
    chk("vsb_replace_pending", 32'(pending), 32'd0);
    chk("vsb_replace_busy", 32'(busy), 32'd1);
    wait_pending("vsb_pend2");
    pulse_vs;
    chk("vsb_x_scale", 32'(x_scale), 32'h04000);
    chk("vsb_y_scale", 32'(y_scale), 32'h10000);
    chk("vsb_out_y", 32'(output_y_res), 32'd269);
    chk("vsb_in_x", 32'(input_x_res), 32'd1919);

    // vs_i and a new accept in the same PEND cycle
    send(100, 1100, 100, 600, 999, 499);
    wait_pending("same_pend");
    @(negedge clk);
    set_req(0, 1920, 0, 1080, 959, 539);
    req_valid = 1'b1;
    vs_i = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vs_i = 1'b0;
    chk("same_in_x", 32'(input_x_res), 32'd999);
    chk("same_in_y", 32'(input_y_res), 32'd499);
    chk("same_start_x", 32'(start_x), 32'd100);
    chk("same_y_scale", 32'(y_scale), 32'h04000);
    chk("same_busy", 32'(busy), 32'd1);
    chk("same_pending", 32'(pending), 32'd0);

    // asynchronous reset in the middle of DIV_Y
    repeat (30) @(posedge clk);
    #1 chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("post_rst_pending", 32'(pending), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
